trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Parametrised machine-mode trap controller.
- Sits between ID/EX, csr_regs and ctrl.
- Arbitrates synchronous exceptions (ECALL/EBREAK), NUM_IRQ prioritised level-sensitive external interrupts and MRET.
- Sequences the mepc/mstatus/mcause CSR writes, then issues a redirect to EX while holding the pipeline.

Parameters:
XLEN, 64, data/address width
NUM_IRQ, 4, number of interrupt request lines (1..16)
IRQ_CAUSE_BASE, 16, mcause exception code of irq_i[0]; line k uses IRQ_CAUSE_BASE+k

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
inst_i  in  32  instruction in ID
inst_addr_i  in  XLEN  address of inst_i
jump_flag_i  in  1  EX is redirecting this cycle
jump_addr_i  in  XLEN  EX redirect target
irq_i  in  NUM_IRQ  level interrupt requests
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc
csr_mstatus  in  XLEN  current mstatus
csr_mie  in  NUM_IRQ  per-line enables
hold_flag_o  out  1  stall request to ctrl
we_o  out  1  CSR write enable
waddr_o  out  XLEN  CSR write address (zero-extended 12-bit CSR number)
data_o  out  XLEN  CSR write data
int_assert_o  out  1  redirect strobe to EX
int_addr_o  out  XLEN  redirect target
irq_ack_o  out  NUM_IRQ  one-hot acknowledge of the taken interrupt

Behaviour:
- Reset: all outputs 0, state IDLE, latched epc/cause 0. Reset applies immediately at any point, including mid-sequence; no partial sequence resumes.
- Event detection, combinational, evaluated only in IDLE.
  - sync: inst_i == ECALL (cause 11) or EBREAK (cause 3).
  - async: pend = irq_i & csr_mie, taken only when csr_mstatus[3] (MIE) = 1. Lowest index wins. cause = {1'b1, (IRQ_CAUSE_BASE+k) zero-extended to XLEN-1}.
  - mret: inst_i == MRET.
  - Priority: sync > async > mret. An async taken while MRET is in ID records that MRET's address, so MRET re-executes.
- epc latched at the event edge.
  - sync: inst_addr_i.
  - async: jump_addr_i if jump_flag_i, else inst_addr_i.
- hold_flag_o = (state != IDLE) | (IDLE & any event).
- State sequence; each state lasts exactly 1 cycle. Outputs are registered and valid during the state named.
  - Trap: IDLE -> MEPC -> MSTATUS -> MCAUSE -> TRAP_JMP -> IDLE.
  - Return: IDLE -> MRET -> MRET_JMP -> IDLE.
- MEPC: we_o=1, waddr_o=0x341, data_o=latched epc.
- MSTATUS: we_o=1, waddr_o=0x300, data_o=csr_mstatus with bit7 (MPIE) := bit3 (MIE) and bit3 := 0.
- MCAUSE: we_o=1, waddr_o=0x342, data_o=latched cause.
- TRAP_JMP: int_assert_o=1, int_addr_o={csr_mtvec[XLEN-1:2],2'b00}. irq_ack_o=one-hot(k) for async, 0 for sync.
- MRET: we_o=1, waddr_o=0x300, data_o=csr_mstatus with bit3 := bit7 and bit7 := 1.
- MRET_JMP: int_assert_o=1, int_addr_o=csr_mepc.
- In every other state/cycle: we_o, waddr_o, data_o, int_assert_o, int_addr_o and irq_ack_o are 0.
- Trap latency: 4 cycles from the event edge to int_assert_o. MRET latency: 2 cycles.
- Events arising outside IDLE are ignored. irq_i levels persist and are re-evaluated on return to IDLE.
- An irq deasserted after the event edge does not abort the sequence.
- An unknown state recovers to IDLE.

Optional Feature:
TRAP_VECTORED_EN.
- Defined: when csr_mtvec[1:0] == 2'b01 and the trap is async, int_addr_o = {csr_mtvec[XLEN-1:2],2'b00} + 4*(IRQ_CAUSE_BASE+k). Sync traps always use base.
- Undefined: mtvec mode bits are ignored; all traps go to base (direct mode only).

Test Plan:
- ECALL at inst_addr_i=0x8000_0010, mtvec=0x8000_0100, mstatus=0x8 -> in order: mepc<=0x8000_0010; mstatus<=0x80; mcause<=11. int_assert_o=1 with int_addr_o=0x8000_0100 four cycles after the event; hold_flag_o high throughout.
- irq_i=4'b0110, mie=4'b1111, MIE=1, jump_flag_i=1, jump_addr_i=0x8000_0200 -> mepc=0x8000_0200; mcause=0x8000_0000_0000_0011 (line 1, code 17); irq_ack_o=4'b0010 in the TRAP_JMP cycle.
- irq_i=4'b0001 with MIE=0, or with mie=0 -> no hold, no writes. Same irq plus EBREAK in ID with MIE=1 -> mcause=3, irq_ack_o=0.
- MRET, mstatus=0x80, mepc=0x8000_0014 -> mstatus<=0x88; int_assert_o with int_addr_o=0x8000_0014 two cycles after the event.
- Assert rst during MSTATUS state -> all outputs 0 immediately. After release: state IDLE, no resumed CSR writes.
- With TRAP_VECTORED_EN, mtvec=0x8000_0101, irq line 2 -> int_addr_o=0x8000_0100+4*18=0x8000_0148. Without the macro -> 0x8000_0100.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller.
// Arbitrates ECALL/EBREAK, prioritised level interrupts and MRET, sequences
// the mepc/mstatus/mcause CSR writes and issues a redirect to EX while
// holding the pipeline.
// Optional build macro: TRAP_VECTORED_EN (vectored mtvec mode for interrupts).
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | waiting for an event
// MEPC     | writing mepc with the latched epc
// MSTATUS  | writing mstatus (MPIE := MIE, MIE := 0)
// MCAUSE   | writing mcause with the latched cause
// TRAP_JMP | redirect to the trap vector, ack taken irq
// MRET     | writing mstatus (MIE := MPIE, MPIE := 1)
// MRET_JMP | redirect to mepc
module trap_ctrl #(
    parameter int XLEN           = 64,
    parameter int NUM_IRQ        = 4,
    parameter int IRQ_CAUSE_BASE = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        inst_i,
    input  logic [XLEN-1:0]    inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [XLEN-1:0]    jump_addr_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [XLEN-1:0]    csr_mtvec,
    input  logic [XLEN-1:0]    csr_mepc,
    input  logic [XLEN-1:0]    csr_mstatus,
    input  logic [NUM_IRQ-1:0] csr_mie,
    output logic               hold_flag_o,
    output logic               we_o,
    output logic [XLEN-1:0]    waddr_o,
    output logic [XLEN-1:0]    data_o,
    output logic               int_assert_o,
    output logic [XLEN-1:0]    int_addr_o,
    output logic [NUM_IRQ-1:0] irq_ack_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEPC     = 3'd1,
        ST_MSTATUS  = 3'd2,
        ST_MCAUSE   = 3'd3,
        ST_TRAP_JMP = 3'd4,
        ST_MRET     = 3'd5,
        ST_MRET_JMP = 3'd6
    } state_t;

    state_t r_state, w_state_nxt;

    logic               w_sync, w_async, w_mret, w_evt, w_irq_hit;
    logic [3:0]         w_irq_idx;
    logic [NUM_IRQ-1:0] w_pend, w_irq_onehot;
    logic [XLEN-1:0]    w_epc_evt, w_cause_evt, w_sync_cause, w_async_cause;
    logic [XLEN-1:0]    w_mst_trap, w_mst_mret, w_trap_base, w_trap_target;

    logic [XLEN-1:0]    r_epc, r_cause;
    logic [NUM_IRQ-1:0] r_ack;

    logic               r_we, w_we_nxt;
    logic [XLEN-1:0]    r_waddr, w_waddr_nxt, r_data, w_data_nxt;
    logic               r_int_assert, w_int_assert_nxt;
    logic [XLEN-1:0]    r_int_addr, w_int_addr_nxt;
    logic [NUM_IRQ-1:0] r_irq_ack, w_irq_ack_nxt;

    assign w_sync  = (inst_i == INST_ECALL) | (inst_i == INST_EBREAK);
    assign w_mret  = (inst_i == INST_MRET);
    assign w_pend  = irq_i & csr_mie;
    assign w_async = csr_mstatus[3] & w_irq_hit;
    assign w_evt   = w_sync | w_async | w_mret;

    // lowest-index pending line wins
    always_comb begin
        w_irq_idx = '0;
        w_irq_hit = 1'b0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (w_pend[k]) begin
                w_irq_idx = k[3:0];
                w_irq_hit = 1'b1;
            end
        end
    end

    assign w_irq_onehot  = NUM_IRQ'(1) << w_irq_idx;
    assign w_sync_cause  = (inst_i == INST_ECALL) ? XLEN'(11) : XLEN'(3);
    assign w_async_cause = {1'b1, (XLEN-1)'(IRQ_CAUSE_BASE) + (XLEN-1)'(w_irq_idx)};
    assign w_cause_evt   = w_sync ? w_sync_cause : w_async_cause;
    assign w_epc_evt     = (w_sync | ~jump_flag_i) ? inst_addr_i : jump_addr_i;

    assign w_mst_trap = {csr_mstatus[XLEN-1:8], csr_mstatus[3], csr_mstatus[6:4],
                         1'b0, csr_mstatus[2:0]};
    assign w_mst_mret = {csr_mstatus[XLEN-1:8], 1'b1, csr_mstatus[6:4],
                         csr_mstatus[7], csr_mstatus[2:0]};

    assign w_trap_base = {csr_mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    // async causes carry bit XLEN-1; the low bits are the code used as vector index
    assign w_trap_target = (csr_mtvec[1:0] == 2'b01 && r_cause[XLEN-1])
                         ? w_trap_base + {r_cause[XLEN-3:0], 2'b00}
                         : w_trap_base;
`else
    logic w_unused_mtvec_mode;
    assign w_unused_mtvec_mode = ^csr_mtvec[1:0];
    assign w_trap_target = w_trap_base;
`endif

    assign hold_flag_o = ~rst & ((r_state != ST_IDLE) | w_evt);

    // next state and the registered outputs belonging to that state
    always_comb begin
        w_state_nxt      = ST_IDLE;
        w_we_nxt         = 1'b0;
        w_waddr_nxt      = '0;
        w_data_nxt       = '0;
        w_int_assert_nxt = 1'b0;
        w_int_addr_nxt   = '0;
        w_irq_ack_nxt    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sync || w_async) w_state_nxt = ST_MEPC;
                else if (w_mret)       w_state_nxt = ST_MRET;
                else                   w_state_nxt = ST_IDLE;
            end
            ST_MEPC:     w_state_nxt = ST_MSTATUS;
            ST_MSTATUS:  w_state_nxt = ST_MCAUSE;
            ST_MCAUSE:   w_state_nxt = ST_TRAP_JMP;
            ST_MRET:     w_state_nxt = ST_MRET_JMP;
            default:     w_state_nxt = ST_IDLE;
        endcase
        case (w_state_nxt)
            ST_MEPC: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = XLEN'(12'h341);
                w_data_nxt  = w_epc_evt;
            end
            ST_MSTATUS: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = XLEN'(12'h300);
                w_data_nxt  = w_mst_trap;
            end
            ST_MCAUSE: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = XLEN'(12'h342);
                w_data_nxt  = r_cause;
            end
            ST_TRAP_JMP: begin
                w_int_assert_nxt = 1'b1;
                w_int_addr_nxt   = w_trap_target;
                w_irq_ack_nxt    = r_ack;
            end
            ST_MRET: begin
                w_we_nxt    = 1'b1;
                w_waddr_nxt = XLEN'(12'h300);
                w_data_nxt  = w_mst_mret;
            end
            ST_MRET_JMP: begin
                w_int_assert_nxt = 1'b1;
                w_int_addr_nxt   = csr_mepc;
            end
            default: ;
        endcase
    end

    // state register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_data       <= '0;
            r_int_assert <= 1'b0;
            r_int_addr   <= '0;
            r_irq_ack    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_we         <= w_we_nxt;
            r_waddr      <= w_waddr_nxt;
            r_data       <= w_data_nxt;
            r_int_assert <= w_int_assert_nxt;
            r_int_addr   <= w_int_addr_nxt;
            r_irq_ack    <= w_irq_ack_nxt;
        end
    end

    // capture epc, cause and ack mask at the trap event edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc   <= '0;
            r_cause <= '0;
            r_ack   <= '0;
        end else if (r_state == ST_IDLE && (w_sync || w_async)) begin
            r_epc   <= w_epc_evt;
            r_cause <= w_cause_evt;
            r_ack   <= w_sync ? '0 : w_irq_onehot;
        end
    end

    assign we_o         = r_we;
    assign waddr_o      = r_waddr;
    assign data_o       = r_data;
    assign int_assert_o = r_int_assert;
    assign int_addr_o   = r_int_addr;
    assign irq_ack_o    = r_irq_ack;

endmodule
